// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings and the data width used by both TX and RX.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    CLEANUP   = 3'd5,
    WAIT_HIGH = 3'd6
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input; the reset value is a parameter so idle-high
// and idle-low lines can share it.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic i_Async,
  output logic o_Sync
);

  logic r_Sync1;
  logic r_Sync2;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_Sync1 <= RST_VAL;
      r_Sync2 <= RST_VAL;
    end else begin
      r_Sync1 <= i_Async;
      r_Sync2 <= r_Sync1;
    end
  end

  assign o_Sync = r_Sync2;

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receiver: 8N1 framing with centre-of-bit sampling and glitch rejection.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_sampler #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_Frame_Err,
  output logic       o_Parity_Err
);
  import uart_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic                 w_Rx;
  rx_state_t            r_State,  w_State;
  logic [CNT_W-1:0]     r_Count,  w_Count;
  logic [2:0]           r_Index,  w_Index;
  logic [DATA_BITS-1:0] r_Data,   w_Data;
  logic [DATA_BITS-1:0] r_RX_Byte, w_Byte;
  logic                 r_Active, w_Active;
  logic                 r_RX_DV,  w_DV;
  logic                 r_Frame_Err, w_FE;
  logic                 w_Tick;
`ifdef UART_RX_PARITY_EN
  logic                 r_Par_Bad, w_Par_Bad;
  logic                 r_Parity_Err, w_PE;
`endif

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .i_Clock (i_Clock),
    .i_Rst_L (i_Rst_L),
    .i_Async (i_RX_Serial),
    .o_Sync  (w_Rx)
  );

  assign w_Tick = (r_Count == LAST);

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State     <= IDLE;
      r_Count     <= '0;
      r_Index     <= '0;
      r_Data      <= '0;
      r_RX_Byte   <= '0;
      r_Active    <= 1'b0;
      r_RX_DV     <= 1'b0;
      r_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_Par_Bad    <= 1'b0;
      r_Parity_Err <= 1'b0;
`endif
    end else begin
      r_State     <= w_State;
      r_Count     <= w_Count;
      r_Index     <= w_Index;
      r_Data      <= w_Data;
      r_RX_Byte   <= w_Byte;
      r_Active    <= w_Active;
      r_RX_DV     <= w_DV;
      r_Frame_Err <= w_FE;
`ifdef UART_RX_PARITY_EN
      r_Par_Bad    <= w_Par_Bad;
      r_Parity_Err <= w_PE;
`endif
    end
  end

  always_comb begin
    w_State  = r_State;
    w_Count  = r_Count;
    w_Index  = r_Index;
    w_Data   = r_Data;
    w_Byte   = r_RX_Byte;
    w_Active = r_Active;
    w_DV     = 1'b0;
    w_FE     = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_Par_Bad = r_Par_Bad;
    w_PE      = 1'b0;
`endif
    case (r_State)
      IDLE: begin
        w_Count = '0;
        w_Index = '0;
`ifdef UART_RX_PARITY_EN
        w_Par_Bad = 1'b0;
`endif
        if (!w_Rx) w_State = START;
      end
      START: begin
        // A line that is high again at mid start bit was a glitch, not a frame.
        if (r_Count == HALF) begin
          w_Count = '0;
          if (!w_Rx) begin
            w_State  = DATA;
            w_Active = 1'b1;
          end else begin
            w_State = IDLE;
          end
        end else begin
          w_Count = r_Count + 1'b1;
        end
      end
      DATA: begin
        if (w_Tick) begin
          w_Count         = '0;
          w_Data[r_Index] = w_Rx;
          if (r_Index == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_State = PARITY;
`else
            w_State = STOP;
`endif
          end else begin
            w_Index = r_Index + 3'd1;
          end
        end else begin
          w_Count = r_Count + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_Tick) begin
          w_Count   = '0;
          w_Par_Bad = w_Rx ^ (^r_Data);
          w_State   = STOP;
        end else begin
          w_Count = r_Count + 1'b1;
        end
      end
`endif
      STOP: begin
        if (w_Tick) begin
          w_Count  = '0;
          w_Active = 1'b0;
          if (w_Rx) begin
`ifdef UART_RX_PARITY_EN
            if (r_Par_Bad) begin
              w_PE = 1'b1;
            end else begin
              w_Byte = r_Data;
              w_DV   = 1'b1;
            end
`else
            w_Byte = r_Data;
            w_DV   = 1'b1;
`endif
            w_State = CLEANUP;
          end else begin
            // Low stop bit: wait for the line to recover so a break is not re-framed.
            w_FE    = 1'b1;
            w_State = WAIT_HIGH;
          end
        end else begin
          w_Count = r_Count + 1'b1;
        end
      end
      CLEANUP:   w_State = IDLE;
      WAIT_HIGH: if (w_Rx) w_State = IDLE;
      default:   w_State = IDLE;
    endcase
  end

  assign o_RX_DV     = r_RX_DV;
  assign o_RX_Byte   = r_RX_Byte;
  assign o_RX_Active = r_Active;
  assign o_Frame_Err = r_Frame_Err;
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = r_Parity_Err;
`else
  assign o_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: frame-level timeline model of expected strobes, compared every cycle.
module tb_uart_rx_sampler;

  localparam int CPB = 8;
  localparam int H   = (CPB - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int STOP_LAT = 86;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int STOP_LAT = 78;
`endif
  localparam int SO = 3 + H + (9 + (PAR_EN ? 1 : 0)) * CPB;

  logic       i_Clock = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic       i_RX_Serial = 1'b1;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Active;
  logic       o_Frame_Err;
  logic       o_Parity_Err;

  uart_rx_sampler #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock      (i_Clock),
    .i_Rst_L      (i_Rst_L),
    .i_RX_Serial  (i_RX_Serial),
    .o_RX_DV      (o_RX_DV),
    .o_RX_Byte    (o_RX_Byte),
    .o_RX_Active  (o_RX_Active),
    .o_Frame_Err  (o_Frame_Err),
    .o_Parity_Err (o_Parity_Err)
  );

  always #5 i_Clock = ~i_Clock;

  int cyc = 0;
  always @(posedge i_Clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // kind: 0 good byte, 1 framing error, 2 parity error
  typedef struct {
    int         e0;
    int         kind;
    logic [7:0] b;
  } rec_t;
  rec_t q[$];

  logic [7:0]  exp_byte = 8'h00;
  logic        e_dv, e_fe, e_pe, e_act;
  logic [11:0] got_v, exp_v;
  int          dv_cnt = 0, fe_cnt = 0, pe_cnt = 0, act_rise = 0;
  int          last_dv_cyc = 0;
  logic [7:0]  last_dv_byte = 8'h00, prev_dv_byte = 8'h00;
  logic        prev_act = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the frame timeline.
  always @(negedge i_Clock) begin
    e_dv = 1'b0; e_fe = 1'b0; e_pe = 1'b0; e_act = 1'b0;
    if (!i_Rst_L) begin
      q.delete();
      exp_byte = 8'h00;
    end else begin
      foreach (q[k]) begin
        if (cyc >= q[k].e0 + 3 + H && cyc < q[k].e0 + SO) e_act = 1'b1;
        if (cyc == q[k].e0 + SO) begin
          case (q[k].kind)
            0: begin e_dv = 1'b1; exp_byte = q[k].b; end
            1: e_fe = 1'b1;
            default: e_pe = 1'b1;
          endcase
        end
      end
      while (q.size() > 0 && cyc >= q[0].e0 + SO) void'(q.pop_front());
    end
    got_v = {o_RX_DV, o_Frame_Err, o_Parity_Err, o_RX_Active, o_RX_Byte};
    exp_v = {e_dv, e_fe, e_pe, e_act, exp_byte};
    chk($sformatf("cycle%0d {dv,fe,pe,act,byte}", cyc), {20'd0, got_v}, {20'd0, exp_v});
    if (o_RX_DV) begin
      dv_cnt++;
      last_dv_cyc  = cyc;
      prev_dv_byte = last_dv_byte;
      last_dv_byte = o_RX_Byte;
    end
    if (o_Frame_Err) fe_cnt++;
    if (o_Parity_Err) pe_cnt++;
    if (o_RX_Active && !prev_act) act_rise++;
    prev_act = o_RX_Active;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_Clock);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit par_ok,
                            input int hold, output int e0);
    rec_t r;
    r.e0 = cyc + 1;
    r.b  = b;
    r.kind = !stop_ok ? 1 : ((PAR_EN && !par_ok) ? 2 : 0);
    q.push_back(r);
    e0 = r.e0;
    i_RX_Serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      i_RX_Serial = b[i];
      tick(CPB);
    end
    if (PAR_EN) begin
      i_RX_Serial = (^b) ^ ~par_ok;
      tick(CPB);
    end
    i_RX_Serial = stop_ok;
    tick(CPB);
    if (!stop_ok) begin
      tick(hold);
      i_RX_Serial = 1'b1;
    end
  endtask

  task automatic glitch(input int len);
    i_RX_Serial = 1'b0;
    tick(len);
    i_RX_Serial = 1'b1;
    tick(2 * CPB);
  endtask

  int e0, d0, f0, p0, a0, gap, kind;
  rec_t rr;
  logic [7:0] rb;

  initial begin
    tick(4);
    chk("reset_dv", o_RX_DV, 0);
    chk("reset_byte", o_RX_Byte, 8'h00);
    chk("reset_active", o_RX_Active, 0);
    chk("reset_ferr", o_Frame_Err, 0);
    chk("reset_perr", o_Parity_Err, 0);
    i_Rst_L = 1'b1;
    tick(20);

    d0 = dv_cnt; f0 = fe_cnt;
    send_frame(8'hA5, 1'b1, 1'b1, 0, e0);
    tick(4);
    chk("a5_dv_count", dv_cnt - d0, 1);
    chk("a5_latency", last_dv_cyc - e0, STOP_LAT);
    chk("a5_byte", last_dv_byte, 8'hA5);
    chk("a5_no_ferr", fe_cnt - f0, 0);

    d0 = dv_cnt; f0 = fe_cnt;
    send_frame(8'h00, 1'b1, 1'b1, 0, e0);
    send_frame(8'hFF, 1'b1, 1'b1, 0, e0);
    tick(4);
    chk("b2b_dv_count", dv_cnt - d0, 2);
    chk("b2b_first", prev_dv_byte, 8'h00);
    chk("b2b_second", last_dv_byte, 8'hFF);
    chk("b2b_no_ferr", fe_cnt - f0, 0);

    d0 = dv_cnt; f0 = fe_cnt; a0 = act_rise;
    glitch(2);
    chk("glitch_dv", dv_cnt - d0, 0);
    chk("glitch_ferr", fe_cnt - f0, 0);
    chk("glitch_active", act_rise - a0, 0);

    d0 = dv_cnt; f0 = fe_cnt; a0 = act_rise;
    send_frame(8'h3C, 1'b0, 1'b1, 40, e0);
    tick(2 * CPB);
    chk("ferr_count", fe_cnt - f0, 1);
    chk("ferr_no_dv", dv_cnt - d0, 0);
    chk("ferr_byte_held", o_RX_Byte, 8'hFF);
    chk("ferr_one_frame", act_rise - a0, 1);

    // Abort a frame with reset during data bit 4.
    rr.e0 = cyc + 1; rr.kind = 0; rr.b = 8'h96;
    q.push_back(rr);
    i_RX_Serial = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      i_RX_Serial = rr.b[i];
      tick(CPB);
    end
    i_RX_Serial = rr.b[4];
    tick(3);
    chk("mid_active", o_RX_Active, 1);
    i_Rst_L = 1'b0;
    i_RX_Serial = 1'b1;
    #1;
    chk("rst_dv", o_RX_DV, 0);
    chk("rst_byte", o_RX_Byte, 8'h00);
    chk("rst_active", o_RX_Active, 0);
    chk("rst_ferr", o_Frame_Err, 0);
    chk("rst_perr", o_Parity_Err, 0);
    tick(3);
    i_Rst_L = 1'b1;
    tick(2 * CPB);
    d0 = dv_cnt;
    send_frame(8'h5A, 1'b1, 1'b1, 0, e0);
    tick(4);
    chk("after_rst_dv", dv_cnt - d0, 1);
    chk("after_rst_byte", last_dv_byte, 8'h5A);

    if (PAR_EN) begin
      d0 = dv_cnt; p0 = pe_cnt;
      send_frame(8'h07, 1'b1, 1'b1, 0, e0);
      tick(4);
      chk("par_good_dv", dv_cnt - d0, 1);
      chk("par_good_byte", last_dv_byte, 8'h07);
      d0 = dv_cnt;
      send_frame(8'h07, 1'b1, 1'b0, 0, e0);
      tick(4);
      chk("par_bad_perr", pe_cnt - p0, 1);
      chk("par_bad_no_dv", dv_cnt - d0, 0);
    end

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      rb   = 8'($urandom_range(0, 255));
      gap  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20);
      if (kind == 6) begin
        send_frame(rb, 1'b0, 1'b1, $urandom_range(0, 40), e0);
        tick(2 * CPB + gap);
      end else if (kind == 7) begin
        send_frame(rb, 1'b1, 1'b0, 0, e0);
        tick(gap);
      end else if (kind == 8) begin
        glitch($urandom_range(1, 3));
        tick(gap);
      end else begin
        send_frame(rb, 1'b1, 1'b1, 0, e0);
        tick(gap);
      end
    end
    tick(3 * CPB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

Byte-oriented UART receiver: 8 data bits, LSB first, one start bit, one stop bit, optional even parity bit. Synchronises the asynchronous serial line, samples each bit at its centre, and delivers each good byte with a one-cycle valid strobe. Framing errors are reported, and false starts caused by line glitches are rejected. It is the receive-side companion to the team's UART transmitter and uses the same CLKS_PER_BIT convention, so a TX/RX pair configured alike interoperates directly.

## Interface
- CLKS_PER_BIT, default 217: i_Clock frequency / baud rate. Must be ≥ 4. Half-bit value H = (CLKS_PER_BIT-1)/2, integer division.
- i_Clock  input  1  system clock; all logic is on the rising edge.
- i_Rst_L  input  1  reset, asynchronous, active-low.
- i_RX_Serial  input  1  asynchronous serial line; idles high.
- o_RX_DV  output  1  one-cycle strobe; o_RX_Byte is valid in the same cycle.
- o_RX_Byte  output  8  last good byte; holds its value between strobes.
- o_RX_Active  output  1  high from start-bit acceptance until the stop bit has been sampled.
- o_Frame_Err  output  1  one-cycle strobe; the stop bit was sampled low.
- o_Parity_Err  output  1  one-cycle strobe; parity mismatch. Tied 0 when parity is compiled out.

## Operation
- Input path: 2-flop synchroniser (r_Sync1, r_Sync2) with reset value 1. The FSM sees only r_Sync2.
- Clock counter is $clog2(CLKS_PER_BIT)+1 bits wide. Bit index is 3 bits.
- IDLE: counter=0, index=0. r_Sync2==0 → START.
- START: count up to H. At count==H, sample the line. If low: → DATA, counter=0, o_RX_Active=1. If high: glitch → IDLE, with no strobe and no error.
- DATA: count 0..CLKS_PER_BIT-1. At the terminal count, write the sample to data[index] and reset the counter. If index<7, increment it; otherwise → PARITY (when compiled in) or → STOP.
- PARITY: same timing as one data bit. Sample p. Set r_Par_Bad = p ^ (^data).
- STOP: same timing as one data bit. At the sample point, drop o_RX_Active.
  - Sample=1 and r_Par_Bad=0: load o_RX_Byte, pulse o_RX_DV → CLEANUP.
  - Sample=1 and r_Par_Bad=1: pulse o_Parity_Err. o_RX_Byte is unchanged and there is no DV → CLEANUP.
  - Sample=0: pulse o_Frame_Err. o_RX_Byte is unchanged and there is no DV → WAIT_HIGH.
- CLEANUP: one cycle → IDLE.
- WAIT_HIGH: stay until r_Sync2==1 (break/low line), then → IDLE. This prevents a held-low line from producing repeated frames.
- Unused state encodings → IDLE.
- Reset mid-frame: all state is discarded immediately. After release the FSM is in IDLE, and a line still low is treated as a new start.

## Timing
- Reset values: o_RX_DV=0, o_RX_Byte=8'h00, o_RX_Active=0, o_Frame_Err=0, o_Parity_Err=0, state=IDLE, sync flops=1.
- Edge E0 is the first rising edge that registers i_RX_Serial low into r_Sync1. START is entered at E0+2.
- Start sample at E0+3+H. Data bit i sampled at E0+3+H+(i+1)·CLKS_PER_BIT.
- Stop sample, and the o_RX_DV/err strobe registered, at E0+3+H+9·CLKS_PER_BIT. With parity, add CLKS_PER_BIT.
- All strobes are exactly one cycle wide and mutually exclusive.
- Back-to-back frames: a start edge arriving during CLEANUP is detected in IDLE on the next cycle. No frame is lost at a stop bit of nominal length.
- There is no backpressure. The consumer must take o_RX_Byte on o_RX_DV or the byte is overwritten by the next frame.

## Configuration
- UART_RX_PARITY_EN defined: the PARITY state exists and even parity is checked. o_Parity_Err is live.
- Not defined: the frame is start+8+stop only. The PARITY state is absent, r_Par_Bad is constant 0, and o_Parity_Err=0.

## Structure
- Shared package uart_pkg holds the state encodings (IDLE, START, DATA, PARITY, STOP, CLEANUP, WAIT_HIGH; 3-bit) and the data-width constant 8. The transmitter shares the width constant.
- One sub-module, uart_rx_sync: the 2-flop synchroniser with parameterised reset value. It is reused by other async inputs.

## Test plan
All scenarios use CLKS_PER_BIT=8, H=3.
- Send 0xA5 at nominal baud → single o_RX_DV, o_RX_Byte=0xA5, strobe at E0+3+3+72 (=E0+78 edges), o_Frame_Err=0.
- Send 0x00 then 0xFF back-to-back, no idle gap → two DV strobes, bytes 0x00 then 0xFF, no errors.
- 2-cycle low glitch on an idle line → no DV, no error, o_RX_Active never rises, FSM back in IDLE.
- Send 0x3C with the stop bit forced low, then hold the line low for 40 cycles → one o_Frame_Err. No DV, o_RX_Byte keeps its prior value, and no second frame starts until the line returns high.
- Assert i_Rst_L low during data bit 4 of a frame → all outputs are at reset values immediately. The next full frame, 0x5A, is received correctly.
- With UART_RX_PARITY_EN: 0x07 sent with parity 1 → DV, byte 0x07. 0x07 sent with parity 0 → o_Parity_Err, no DV.
